bus_txn_sequencer: RTL and testbench
====================================

// Module: bus_txn_sequencer
// PURPOSE
//   Two-master, three-slave bus sequencer: FSM plus address/data path in one block.
//   Alternates strictly between master 1 and master 2 (round robin).
//   Each master gets one address phase, then one data phase.
//   The registered address is decoded into one-hot slave selects; the master's write data is registered onto data_out.
//   Sits between the two master request ports and the slave-select/data fabric.
// PARAMETERS
//   ADDR_W   16  address width (data_in1, data_in2, address)
//   DATA_W   32  data width (data_in3, data_in4, data_out)
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   rst        in   1       synchronous, active-low reset (sampled on posedge clk)
//   data_in1   in   ADDR_W  master 1 address
//   data_in2   in   ADDR_W  master 2 address
//   data_in3   in   DATA_W  master 1 write data
//   data_in4   in   DATA_W  master 2 write data
//   address    out  ADDR_W  registered bus address of the current owner
//   data_out   out  DATA_W  registered bus write data
//   slave_0    out  1       select, address[15:13]==3'b001
//   slave_1    out  1       select, address[15:13]==3'b010
//   slave_2    out  1       select, address[15:13]==3'b011
//   aout       out  1       address-phase flag (1 during address phase)
//   dvalid     out  1       data-phase flag (1 during data phase)
//   master     out  1       current owner: 0 = master 1, 1 = master 2
// BEHAVIOUR
// - Reset (rst==0 at posedge): all of the following clear.
//     state=IDLE; address=0; data_out=0; aout=0; dvalid=0; master=0.
//     slave_0..2 read 0.
//   Reset has priority over everything and may occur in any state; it takes effect on that edge.
// - FSM states: IDLE, ADDR_M1, DATA_M1, ADDR_M2, DATA_M2 (registered state).
//   With rst==1 the transitions are unconditional, one per clock:
//     IDLE -> ADDR_M1 -> DATA_M1 -> ADDR_M2 -> DATA_M2 -> ADDR_M1 ...
// - Register updates on the edge that enters a state:
//     ADDR_M1: address<=data_in1, master<=0, aout<=1, dvalid<=0
//     DATA_M1: data_out<=data_in3, aout<=0, dvalid<=1; address held
//     ADDR_M2: address<=data_in2, master<=1, aout<=1, dvalid<=0
//     DATA_M2: data_out<=data_in4, aout<=0, dvalid<=1; address held
//   data_out holds its value through the following address phase.
// - Inputs are sampled only on the entering edge; changes at other times are ignored.
// - Latency: an address appears 1 clock after the FSM enters its slot; its data appears 1 clock later.
//   Each master transaction spans 2 clocks; the full round-robin period is 4 clocks.
// - Slave decode:
//     combinational from registered address[ADDR_W-1:ADDR_W-3], at most one select high;
//     forced to all-zero when state==IDLE;
//     address[15:13] values 000 or 1xx are unmapped: all selects 0, but the FSM still advances normally.
// - Selects stay asserted across the address and data phases of the same master.
// - Internal structure: 2:1 address mux + address register; 2:1 data mux + data register.
//   The FSM drives the mux selects and register loads.
// - No backpressure or handshake from the slaves; the sequence is free-running.
// TESTING
// - Reset hold: rst=0 for 3 clocks -> address=0, data_out=0, aout=0, dvalid=0, all slave_x=0, master=0.
// - First transaction after release: data_in1=16'h2008, data_in3=567.
//     1st posedge with rst=1 -> address=16'h2008, aout=1, slave_0=1, master=0.
//     2nd posedge -> data_out=567, dvalid=1, slave_0 still 1.
// - Second master: data_in2=16'h4008, data_in4=434.
//     3rd posedge -> address=16'h4008, slave_1=1, master=1, aout=1.
//     4th posedge -> data_out=434, dvalid=1.
//     5th posedge -> address=16'h2008 again (wrap to master 1).
// - Decode sweep: address[15:13]=011 -> slave_2=1; 000 / 100 / 111 -> no select.
//   In all cases aout/dvalid keep toggling every clock.
// - Mid-transaction reset: assert rst=0 while in DATA_M2 -> next edge all outputs cleared.
//   Release -> restart at ADDR_M1 with data_in1.
// - Input change outside the sampling edge: alter data_in3 during ADDR_M1 mid-cycle -> data_out takes the value present at the DATA_M1 entry edge only.

Source files
------------

// File: rtl/bus_txn_sequencer.sv
// bus_txn_sequencer: round-robin two-master address/data phase sequencer with one-hot slave decode
module bus_txn_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] data_in1,
  input  logic [ADDR_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              slave_0,
  output logic              slave_1,
  output logic              slave_2,
  output logic              aout,
  output logic              dvalid,
  output logic              master
);
  typedef enum logic [2:0] {IDLE, ADDR_M1, DATA_M1, ADDR_M2, DATA_M2} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic aout_q, aout_d, dvalid_q, dvalid_d, master_q, master_d;
  logic [2:0] region;
  always_comb begin
    state_d  = state_q == IDLE    ? ADDR_M1 :
               state_q == ADDR_M1 ? DATA_M1 :
               state_q == DATA_M1 ? ADDR_M2 :
               state_q == ADDR_M2 ? DATA_M2 : ADDR_M1;
    address_d = state_d == ADDR_M1 ? data_in1 : state_d == ADDR_M2 ? data_in2 : address_q;
    data_d    = state_d == DATA_M1 ? data_in3 : state_d == DATA_M2 ? data_in4 : data_q;
    master_d  = state_d == ADDR_M2 ? 1'b1 : state_d == ADDR_M1 ? 1'b0 : master_q;
    aout_d    = state_d == ADDR_M1 || state_d == ADDR_M2;
    dvalid_d  = state_d == DATA_M1 || state_d == DATA_M2;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      address_q <= '0;
      data_q    <= '0;
      aout_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      master_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      data_q    <= data_d;
      aout_q    <= aout_d;
      dvalid_q  <= dvalid_d;
      master_q  <= master_d;
    end
  end
  // Decode the top three address bits; regions 000 and 1xx map to no slave
  assign region   = address_q[ADDR_W-1 -: 3];
  assign slave_0  = state_q != IDLE && region == 3'b001;
  assign slave_1  = state_q != IDLE && region == 3'b010;
  assign slave_2  = state_q != IDLE && region == 3'b011;
  assign address  = address_q;
  assign data_out = data_q;
  assign aout     = aout_q;
  assign dvalid   = dvalid_q;
  assign master   = master_q;
endmodule

// File: tb/tb_bus_txn_sequencer.sv
// tb_bus_txn_sequencer: randomized scoreboard bench against a slot-based reference model
module tb_bus_txn_sequencer;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] a1 = '0, a2 = '0, address;
  logic [31:0] d3 = '0, d4 = '0, data_out;
  logic s0, s1, s2, aout, dvalid, master;
  int total = 0, bad = 0;
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic ao, dv, m;
    logic [2:0] sel;
  } exp_t;
  exp_t q[$];
  exp_t mdl;
  bit run = 0;
  int slot = 0;

  bus_txn_sequencer dut (
    .clk(clk), .rst(rst), .data_in1(a1), .data_in2(a2), .data_in3(d3), .data_in4(d4),
    .address(address), .data_out(data_out), .slave_0(s0), .slave_1(s1), .slave_2(s2),
    .aout(aout), .dvalid(dvalid), .master(master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position within the 4-slot round robin decides what each edge loads
  task automatic model();
    int t;
    if (!rst) begin
      run = 0;
      mdl = '{a: '0, d: '0, ao: 0, dv: 0, m: 0, sel: '0};
    end else begin
      slot = run ? (slot + 1) % 4 : 0;
      run = 1;
      if (slot == 0) begin mdl.a = a1; mdl.m = 0; end
      if (slot == 1) mdl.d = d3;
      if (slot == 2) begin mdl.a = a2; mdl.m = 1; end
      if (slot == 3) mdl.d = d4;
      mdl.ao = (slot % 2) == 0;
      mdl.dv = (slot % 2) == 1;
    end
    t = int'(mdl.a[15:13]);
    mdl.sel = (run && t >= 1 && t <= 3) ? 3'(1 << (t - 1)) : 3'b000;
  endtask

  task automatic step(input logic r, input logic [15:0] x1, input logic [15:0] x2,
                      input logic [31:0] x3, input logic [31:0] x4);
    rst = r; a1 = x1; a2 = x2; d3 = x3; d4 = x4;
    @(posedge clk);
    model();
    q.push_back(mdl);
    #2;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("address", 32'(address), 32'(e.a));
      chk("data_out", data_out, e.d);
      chk("aout", 32'(aout), 32'(e.ao));
      chk("dvalid", 32'(dvalid), 32'(e.dv));
      chk("master", 32'(master), 32'(e.m));
      chk("selects", 32'({s2, s1, s0}), 32'(e.sel));
    end
  end

  initial begin
    #2;
    repeat (3) step(0, 16'hffff, 16'hffff, 32'hdead, 32'hbeef);
    step(1, 16'h2008, 16'h4008, 32'd111, 32'd434);
    step(1, 16'h0000, 16'h4008, 32'd567, 32'd434);
    step(1, 16'h0000, 16'h4008, 32'd1, 32'd434);
    step(1, 16'h2008, 16'h0000, 32'd2, 32'd434);
    step(1, 16'h2008, 16'h0000, 32'd3, 32'd4);
    step(1, 16'h6001, 16'h0123, 32'd5, 32'd6);
    step(1, 16'h0000, 16'h8000, 32'd7, 32'd8);
    step(1, 16'h0000, 16'he000, 32'd9, 32'd10);
    step(0, 16'h1111, 16'h2222, 32'd11, 32'd12);
    step(1, 16'h7fff, 16'ha000, 32'd13, 32'd14);
    step(1, 16'h1fff, 16'h3000, 32'd15, 32'd16);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) != 0), 16'($urandom), 16'($urandom), $urandom, $urandom);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
